// File: rtl/datapath_mc.sv
// Multi-cycle datapath: register file, flagged ALU and an iterative shift-add multiplier.
// Optional DATAPATH_MC_BYPASS_EN forwards the running accumulator to reads of the MUL destination.
module datapath_mc #(
    parameter int NBITS      = 8,
    parameter int NREGS      = 32,
    parameter int WIDTH_ALUF = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [$clog2(NREGS)-1:0] RS1,
    input  logic [$clog2(NREGS)-1:0] RS2,
    input  logic [$clog2(NREGS)-1:0] RD,
    input  logic [NBITS-1:0]         IMM,
    input  logic [WIDTH_ALUF-1:0]    ALUControl,
    input  logic                     ALUSrc,
    input  logic                     MemtoReg,
    input  logic                     RegWrite,
    input  logic                     link,
    input  logic [NBITS-1:0]         pclink,
    input  logic                     Start,
    output logic                     Busy,
    output logic                     Done,
    output logic                     Zero,
    output logic                     Neg,
    output logic                     Carry,
    output logic                     Overflow,
    output logic [NBITS-1:0]         PCReg,
    output logic [NBITS-3:0]         Address,
    output logic [NBITS-1:0]         WriteData,
    input  logic [NBITS-1:0]         ReadData
);
    localparam int RBITS = $clog2(NREGS);
    localparam int SBITS = $clog2(NBITS);
    localparam int CBITS = $clog2(NBITS + 1);

    localparam logic [WIDTH_ALUF-1:0] OP_SUB = WIDTH_ALUF'(4'b1000);
    localparam logic [WIDTH_ALUF-1:0] OP_AND = WIDTH_ALUF'(4'b0111);
    localparam logic [WIDTH_ALUF-1:0] OP_OR  = WIDTH_ALUF'(4'b0110);
    localparam logic [WIDTH_ALUF-1:0] OP_XOR = WIDTH_ALUF'(4'b0100);
    localparam logic [WIDTH_ALUF-1:0] OP_SLT = WIDTH_ALUF'(4'b0010);
    localparam logic [WIDTH_ALUF-1:0] OP_SLL = WIDTH_ALUF'(4'b0001);
    localparam logic [WIDTH_ALUF-1:0] OP_SRL = WIDTH_ALUF'(4'b0101);
    localparam logic [WIDTH_ALUF-1:0] OP_MUL = WIDTH_ALUF'(4'b1010);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    state_t             next_state;
    logic               launch;
    logic               finish;
    logic               done_q;

    logic [NBITS-1:0]   regs [NREGS];
    logic [NBITS-1:0]   rs1_val;
    logic [NBITS-1:0]   rs2_val;
    logic [NBITS-1:0]   src_a;
    logic [NBITS-1:0]   src_b;
    logic [NBITS-1:0]   sum_b;
    logic [NBITS:0]     sum_full;
    logic [NBITS-1:0]   alu_result;
    logic [NBITS-1:0]   result;
    logic [SBITS-1:0]   shamt;
    logic               is_sub;
    logic               arith;
    logic               reg_we;

    logic [NBITS-1:0]   mcand;
    logic [NBITS-1:0]   mplier;
    logic [NBITS-1:0]   acc;
    logic [CBITS-1:0]   count;
    logic [RBITS-1:0]   mul_rd;

    always_comb begin
        rs1_val = (RS1 == '0) ? '0 : regs[RS1];
        rs2_val = (RS2 == '0) ? '0 : regs[RS2];
`ifdef DATAPATH_MC_BYPASS_EN
        if (Busy && mul_rd != '0) begin
            if (RS1 == mul_rd) rs1_val = acc;
            if (RS2 == mul_rd) rs2_val = acc;
        end
`endif
    end

    assign src_a     = rs1_val;
    assign src_b     = ALUSrc ? IMM : rs2_val;
    assign shamt     = src_b[SBITS-1:0];
    assign is_sub    = (ALUControl == OP_SUB);
    assign sum_b     = is_sub ? ~src_b : src_b;
    assign sum_full  = {1'b0, src_a} + {1'b0, sum_b} + {{NBITS{1'b0}}, is_sub};

    // Unlisted codes fall into the default arm and behave as ADD; MUL exposes the accumulator.
    always_comb begin
        alu_result = sum_full[NBITS-1:0];
        arith      = 1'b0;
        case (ALUControl)
            OP_SUB:  arith = 1'b1;
            OP_AND:  alu_result = src_a & src_b;
            OP_OR:   alu_result = src_a | src_b;
            OP_XOR:  alu_result = src_a ^ src_b;
            OP_SLT:  alu_result = {{(NBITS-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            OP_SLL:  alu_result = src_a << shamt;
            OP_SRL:  alu_result = src_a >> shamt;
            OP_MUL:  alu_result = acc;
            default: arith = 1'b1;
        endcase
    end

    assign Zero      = (alu_result == '0);
    assign Carry     = arith & sum_full[NBITS];
    assign Overflow  = arith & (src_a[NBITS-1] == sum_b[NBITS-1]) & (sum_full[NBITS-1] != src_a[NBITS-1]);
    assign Neg       = alu_result[NBITS-1] ^ Overflow;
    assign PCReg     = rs1_val;
    assign WriteData = rs2_val;
    assign Address   = alu_result[NBITS-1:2];

    always_comb begin
        if (link)
            result = pclink;
        else if (MemtoReg)
            result = ReadData;
        else
            result = alu_result;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // RUN holds one extra cycle with count == 0 so the writeback lands NBITS+1 edges after launch.
    always_comb begin
        next_state = state;
        launch     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (Start && ALUControl == OP_MUL) begin
                    launch     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (count == '0) begin
                    finish     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign Busy   = (state == RUN);
    assign Done   = done_q;
    assign reg_we = RegWrite && (RD != '0) && !Busy && !launch;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            mul_rd <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= finish;
            if (launch) begin
                mcand  <= src_a;
                mplier <= src_b;
                acc    <= '0;
                count  <= CBITS'(NBITS);
                mul_rd <= RD;
            end else if (state == RUN && count != '0) begin
                if (mplier[0])
                    acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count - CBITS'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (finish) begin
            if (mul_rd != '0)
                regs[mul_rd] <= acc;
        end else if (reg_we) begin
            regs[RD] <= result;
        end
    end

endmodule
